// File: rtl/text_ram_writer.sv
// -----------------------------------------------------------------------------
// text_ram_writer
//   Write side of the character text RAM read by the VGA text path. Bytes
//   arrive from upstream (UART RX / keyboard) over a valid/ready handshake and
//   are turned into text-RAM writes at a cursor. CR, backspace, form feed and a
//   full-screen clear are handled here. ram_busy tells the VGA renderer that
//   the RAM is being rewritten.
//
//   COLS*ROWS must not exceed 256 (8-bit cell address).
//
// Ports
//   clk         in   1  system clock, single domain
//   reset       in   1  asynchronous, active-low reset
//   char_data   in   8  incoming byte
//   char_valid  in   1  char_data valid
//   char_ready  out  1  block can accept a byte this cycle
//   clear       in   1  full-screen clear request (level, sampled in IDLE)
//   wr_en       out  1  text RAM write strobe, one cycle per write
//   wr_addr     out  8  text RAM write address
//   wr_data     out  8  text RAM write data
//   ram_busy    out  1  RAM is being rewritten (high during every write)
//   cursor      out  8  current cursor cell, 0..COLS*ROWS-1
// -----------------------------------------------------------------------------
module text_ram_writer #(
    parameter int         COLS  = 16,
    parameter int         ROWS  = 16,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char_data,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic       clear,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       ram_busy,
    output logic [7:0] cursor
);

    localparam int         CELLS          = COLS * ROWS;
    localparam logic [7:0] COLS8          = 8'(COLS);
    localparam logic [7:0] LAST_CELL      = 8'(CELLS - 1);
    localparam logic [7:0] LAST_ROW_START = 8'(CELLS - COLS);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cursor_q, cursor_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       busy_q, busy_d;

    logic       accept;
    logic       start_clear;
    logic [7:0] row_start;

    // Ready is derived from the state register and the clear input so that a
    // clear request and a byte offered in the same cycle can never both be
    // taken: upstream sees ready low in exactly the cycle the clear wins.
    assign char_ready = (state_q == IDLE) && !clear;
    assign accept     = char_valid && char_ready;
    assign row_start  = cursor_q - (cursor_q % COLS8);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statements leaves one unassigned and infers a latch.
        state_d     = state_q;
        cursor_d    = cursor_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        start_clear = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear) begin
                    start_clear = 1'b1;
                end else if (accept) begin
                    case (char_data)
                        CH_CR: begin
                            cursor_d = (cursor_q >= LAST_ROW_START) ? 8'd0
                                                                    : row_start + COLS8;
                        end
                        CH_BS: begin
                            if (cursor_q != 8'd0) begin
                                cursor_d  = cursor_q - 8'd1;
                                wr_en_d   = 1'b1;
                                wr_addr_d = cursor_q - 8'd1;
                                wr_data_d = BLANK;
                            end
                        end
                        CH_FF: start_clear = 1'b1;
                        default: begin
                            if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = cursor_q;
                                wr_data_d = char_data;
                                cursor_d  = (cursor_q == LAST_CELL) ? 8'd0
                                                                    : cursor_q + 8'd1;
                            end
                        end
                    endcase
                end
            end

            CLEAR: begin
                // The registered write strobe doubles as the clear counter:
                // wr_addr_q holds the cell written last. Straight out of reset
                // no write is showing, so the sweep starts at cell 0.
                if (wr_en_q && wr_addr_q == LAST_CELL) begin
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_en_q ? wr_addr_q + 8'd1 : 8'd0;
                    wr_data_d = BLANK;
                end
            end

            default: state_d = IDLE;
        endcase

        // Clear entry emits the write of cell 0 on the same edge.
        if (start_clear) begin
            state_d   = CLEAR;
            cursor_d  = 8'd0;
            wr_en_d   = 1'b1;
            wr_addr_d = 8'd0;
            wr_data_d = BLANK;
        end

        busy_d = wr_en_d;
    end

    // Reset parks the block in CLEAR so power-up always blanks the screen.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset) begin
            state_q   <= CLEAR;
            cursor_q  <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 8'd0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign ram_busy = busy_q;
    assign cursor   = cursor_q;

endmodule

// File: tb/tb_text_ram_writer.sv
// -----------------------------------------------------------------------------
// tb_text_ram_writer
//   Directed bench for text_ram_writer (16x16 cells, blank 0x20). Inputs change
//   on the falling edge; outputs are sampled on the falling edge after the
//   rising edge that acted on them.
// -----------------------------------------------------------------------------
module tb_text_ram_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic       clear;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       ram_busy;
    logic [7:0] cursor;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    text_ram_writer dut (
        .clk        (clk),
        .reset      (reset),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear      (clear),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ram_busy   (ram_busy),
        .cursor     (cursor)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one byte for one cycle; returns on the falling edge after the accept.
    task automatic send(input logic [7:0] b);
        char_data  = b;
        char_valid = 1'b1;
        step();
        char_valid = 1'b0;
    endtask

    // {wr_en, ram_busy, wr_addr, wr_data} after a printable/BS write.
    task automatic send_write(input string tag, input logic [7:0] b,
                              input logic [7:0] addr, input logic [7:0] data,
                              input logic [7:0] cur);
        send(b);
        check(tag, {wr_en, ram_busy, wr_addr, wr_data, cursor},
                   {1'b1, 1'b1, addr, data, cur});
    endtask

    task automatic send_nowrite(input string tag, input logic [7:0] b, input logic [7:0] cur);
        send(b);
        check(tag, {wr_en, ram_busy, char_ready, cursor}, {1'b0, 1'b0, 1'b1, cur});
    endtask

    // Expects the write of cell 'first' to be showing now, then checks the
    // remaining sweep and the return to IDLE.
    task automatic expect_clear(input string tag, input int first);
        for (int i = first; i < 256; i++) begin
            logic [7:0] a;
            a = 8'(i);
            check(tag, {wr_en, ram_busy, char_ready, wr_data, wr_addr, cursor},
                       {1'b1, 1'b1, 1'b0, 8'h20, a, 8'h00});
            step();
        end
        check({tag, "_done"}, {wr_en, ram_busy, char_ready, cursor}, {1'b0, 1'b0, 1'b1, 8'h00});
    endtask

    initial begin
        reset      = 1'b0;
        char_data  = 8'h00;
        char_valid = 1'b0;
        clear      = 1'b0;

        // Reset state.
        step();
        step();
        check("reset_state", {wr_en, ram_busy, char_ready, wr_addr, wr_data, cursor},
                             {1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00});

        // Power-up blanking after release.
        reset = 1'b1;
        check("release_no_write", {wr_en, char_ready}, {1'b0, 1'b0});
        step();
        expect_clear("powerup_clr", 0);

        // 'H','i' back to back.
        char_data  = 8'h48;
        char_valid = 1'b1;
        step();
        check("wr_H", {wr_en, ram_busy, wr_addr, wr_data, cursor}, {1'b1, 1'b1, 8'd0, 8'h48, 8'd1});
        char_data = 8'h69;
        step();
        char_valid = 1'b0;
        check("wr_i", {wr_en, ram_busy, wr_addr, wr_data, cursor}, {1'b1, 1'b1, 8'd1, 8'h69, 8'd2});
        step();
        check("idle_after_hi", {wr_en, ram_busy, cursor}, {1'b0, 1'b0, 8'd2});

        // Backspace from cursor 3.
        send_write("wr_x", 8'h78, 8'd2, 8'h78, 8'd3);
        send_write("bs_3", 8'h08, 8'd2, 8'h20, 8'd2);

        // CR from cursor 5.
        send_write("wr_a", 8'h61, 8'd2, 8'h61, 8'd3);
        send_write("wr_b", 8'h62, 8'd3, 8'h62, 8'd4);
        send_write("wr_c", 8'h63, 8'd4, 8'h63, 8'd5);
        send_nowrite("cr_5", 8'h0D, 8'd16);

        // Walk to the last row with CRs, then to cell 250.
        for (int r = 2; r <= 15; r++) send(8'h0D);
        check("cr_chain", cursor, 8'd240);
        for (int c = 0; c < 9; c++) send(8'h30);
        send_write("wr_tilde", 8'h7E, 8'd249, 8'h7E, 8'd250);
        send_nowrite("cr_last_row", 8'h0D, 8'd0);

        // Backspace at cell 0 is dropped; non-printables are discarded.
        send_nowrite("bs_0", 8'h08, 8'd0);
        send_nowrite("bell", 8'h07, 8'd0);
        send_nowrite("del", 8'h7F, 8'd0);
        send_nowrite("nul", 8'h00, 8'd0);

        // Wrap from cell 255.
        for (int r = 1; r <= 15; r++) send(8'h0D);
        for (int c = 0; c < 15; c++) send(8'h2E);
        check("at_255", cursor, 8'd255);
        send_write("wrap_A", 8'h41, 8'd255, 8'h41, 8'd0);

        // Form feed behaves like clear, forcing the cursor back to 0.
        send_write("wr_k", 8'h6B, 8'd0, 8'h6B, 8'd1);
        send(8'h0C);
        expect_clear("ff_clr", 0);

        // Clear with a byte offered in the same cycle: the byte is refused.
        send_write("wr_q", 8'h71, 8'd0, 8'h71, 8'd1);
        clear      = 1'b1;
        char_data  = 8'h5A;
        char_valid = 1'b1;
        #1;
        check("ready_low_on_clear", char_ready, 1'b0);
        step();
        clear      = 1'b0;
        char_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            logic [7:0] a;
            a = 8'(i);
            check("clr_pre_reset", {wr_en, ram_busy, wr_data, wr_addr, cursor},
                                   {1'b1, 1'b1, 8'h20, a, 8'h00});
            step();
        end
        check("clr_at_100", {wr_en, wr_addr}, {1'b1, 8'd100});

        // Reset mid-clear stops the write at once; the sweep restarts at 0.
        reset = 1'b0;
        #1;
        check("reset_mid_clr", {wr_en, ram_busy, char_ready, wr_addr, cursor},
                               {1'b0, 1'b1, 1'b0, 8'h00, 8'h00});
        step();
        reset = 1'b1;
        step();
        expect_clear("restart_clr", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
